// File: rtl/lcd_show_char.sv
// Glyph renderer: fetches one font ROM row per glyph line and emits one pixel write per bit.
// Each row costs 2 + COLS cycles plus one cycle per stalled pixel. wr_req holds coordinates and colour until wr_ack.
module lcd_show_char #(
  parameter int          H_RES    = 320,
  parameter int          V_RES    = 240,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        en_size,
  output logic        font_sel,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        wr_req,
  output logic [8:0]  wr_x,
  output logic [8:0]  wr_y,
  output logic [15:0] wr_color,
  input  logic        wr_ack,
  output logic        busy,
  output logic        show_char_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_PIXEL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [9:0] LP_H_RES = 10'(H_RES);
  localparam logic [9:0] LP_V_RES = 10'(V_RES);

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_code;
  logic [8:0]  r_x0;
  logic [8:0]  r_y0;
  logic        r_size;
  logic [3:0]  r_row;
  logic [2:0]  r_col;
  logic [7:0]  r_bits;

  logic        w_in_bounds;
  logic        w_adv;
  logic        w_last_col;
  logic        w_last_row;
  logic [10:0] w_addr12;
  logic [10:0] w_addr16;

  assign wr_x        = r_x0 + {6'd0, r_col};
  assign wr_y        = r_y0 + {5'd0, r_row};
  assign wr_color    = r_bits[3'd7 - r_col] ? FG_COLOR : BG_COLOR;
  assign w_in_bounds = ({1'b0, wr_x} < LP_H_RES) && ({1'b0, wr_y} < LP_V_RES);
  // Off-screen pixels still cost one cycle so the row timing is independent of clipping.
  assign w_adv       = (r_state == S_PIXEL) && (!w_in_bounds || wr_ack);
  assign w_last_col  = r_size ? (r_col == 3'd7) : (r_col == 3'd5);
  assign w_last_row  = r_size ? (r_row == 4'd15) : (r_row == 4'd11);

  // code*12 built as code*8 + code*4; the largest result (94*16+15) still fits in 11 bits.
  assign w_addr12  = {1'b0, r_code, 3'd0} + {2'd0, r_code, 2'd0} + {7'd0, r_row};
  assign w_addr16  = {r_code, 4'd0} + {7'd0, r_row};
  assign font_addr = r_size ? w_addr16 : w_addr12;
  assign font_sel  = r_size;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    wr_req         = 1'b0;
    busy           = 1'b1;
    show_char_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (show_char_flag) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_PIXEL;
      S_PIXEL: begin
        wr_req = w_in_bounds;
        if (w_adv && w_last_col) w_next = w_last_row ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        show_char_done = 1'b1;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_code <= 7'd0;
      r_x0   <= 9'd0;
      r_y0   <= 9'd0;
      r_size <= 1'b0;
      r_row  <= 4'd0;
      r_col  <= 3'd0;
      r_bits <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (show_char_flag) begin
            r_code <= (ascii_num > 7'd94) ? 7'd0 : ascii_num;
            r_x0   <= start_x;
            r_y0   <= start_y;
            r_size <= en_size;
            r_row  <= 4'd0;
            r_col  <= 3'd0;
          end
        end
        S_WAIT: r_bits <= font_data;
        S_PIXEL: begin
          if (w_adv) begin
            if (w_last_col) begin
              r_col <= 3'd0;
              if (!w_last_row) r_row <= r_row + 4'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
